// File: rtl/seg7_frame_reader.sv
// rtl/seg7_frame_reader.sv - decodes a multiplexed 7-segment bus back into BCD frames
//
// Purpose: watches a segment bus plus one-hot digit select, accepts each digit once
// its pattern has been stable for STABLE_CYCLES clocks, and assembles NUM_DIGITS
// digits into a frame offered on a valid/ready handshake.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   seg[0:6]      segments a..g, active-high, seg[0]=a
//   dig_sel       one-hot digit enable, bit i = digit i
//   frame_bcd     digit i code at [4i+3:4i] (F = blank, E = unrecognised)
//   blank_mask    bit i set when digit i was blank
//   frame_err     some digit in the frame had an unrecognised pattern
//   frame_valid   frame outputs valid; held stable until accepted
//   frame_ready   consumer accepts the frame
//   overrun       sticky, a completed frame was dropped while one was pending
module seg7_frame_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:6]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);

  typedef enum logic {SCAN, PRESENT} state_t;

  state_t                  state;
  logic [0:6]              prev_seg;
  logic [NUM_DIGITS-1:0]   prev_sel;
  logic [CW-1:0]           run_cnt;
  logic [CW-1:0]           run_next;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] slot_code;
  logic [NUM_DIGITS-1:0]   slot_blank;
  logic [NUM_DIGITS-1:0]   slot_inv;

  logic [3:0]              dec_code;
  logic                    dec_blank;
  logic                    dec_inv;
  logic [4*NUM_DIGITS-1:0] merged_code;
  logic [NUM_DIGITS-1:0]   merged_blank;
  logic [NUM_DIGITS-1:0]   merged_inv;

  logic same;
  logic onehot;
  logic accept;
  logic complete;
  logic handshake;

  always_comb begin
    dec_code  = 4'hE;
    dec_blank = 1'b0;
    dec_inv   = 1'b0;
    case (seg)
      7'b1111110: dec_code = 4'h0;
      7'b0110000: dec_code = 4'h1;
      7'b1101101: dec_code = 4'h2;
      7'b1111001: dec_code = 4'h3;
      7'b0110011: dec_code = 4'h4;
      7'b1011011: dec_code = 4'h5;
      7'b1011111: dec_code = 4'h6;
      7'b1110000: dec_code = 4'h7;
      7'b1111111: dec_code = 4'h8;
      7'b1111011: dec_code = 4'h9;
      7'b0000000: begin
        dec_code  = 4'hF;
        dec_blank = 1'b1;
      end
      default:    dec_inv = 1'b1;
    endcase
  end

  assign same   = (seg == prev_seg) && (dig_sel == prev_sel);
  assign onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - 1'b1)) == '0);

  always_comb begin
    if (!same)
      run_next = CW'(1);
    else if (run_cnt == STABLE_CNT)
      run_next = run_cnt;
    else
      run_next = run_cnt + 1'b1;
  end

  // A fresh run (load of 1) also counts as "becoming" stable, which is what lets
  // STABLE_CYCLES=1 accept every changed sample even after a saturated run.
  assign accept    = onehot && (run_next == STABLE_CNT) && (!same || run_cnt != STABLE_CNT);
  assign complete  = accept && ((mask | dig_sel) == {NUM_DIGITS{1'b1}});
  assign handshake = frame_valid && frame_ready;

  // Slots with the incoming digit merged in; used both to update the slots and to
  // load a frame on the completing edge without waiting a cycle.
  always_comb begin
    merged_code  = slot_code;
    merged_blank = slot_blank;
    merged_inv   = slot_inv;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_sel[i]) begin
        merged_code[4*i +: 4] = dec_code;
        merged_blank[i]       = dec_blank;
        merged_inv[i]         = dec_inv;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      prev_seg    <= '0;
      prev_sel    <= '0;
      run_cnt     <= '0;
      mask        <= '0;
      slot_code   <= '0;
      slot_blank  <= '0;
      slot_inv    <= '0;
      frame_bcd   <= '0;
      blank_mask  <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      prev_seg <= seg;
      prev_sel <= dig_sel;
      run_cnt  <= run_next;

      if (accept) begin
        slot_code  <= merged_code;
        slot_blank <= merged_blank;
        slot_inv   <= merged_inv;
        mask       <= complete ? '0 : (mask | dig_sel);
      end

      case (state)
        SCAN: begin
          if (complete) begin
            frame_bcd   <= merged_code;
            blank_mask  <= merged_blank;
            frame_err   <= |merged_inv;
            frame_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (complete) begin
            if (handshake) begin
              frame_bcd  <= merged_code;
              blank_mask <= merged_blank;
              frame_err  <= |merged_inv;
              overrun    <= 1'b0;
            end else begin
              overrun <= 1'b1;
            end
          end else if (handshake) begin
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            state       <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_frame_reader.sv
// tb/tb_seg7_frame_reader.sv - directed self-checking bench for seg7_frame_reader
module tb_seg7_frame_reader;

  localparam logic [6:0] P0  = 7'b1111110;
  localparam logic [6:0] P1  = 7'b0110000;
  localparam logic [6:0] P3  = 7'b1111001;
  localparam logic [6:0] P8  = 7'b1111111;
  localparam logic [6:0] P9  = 7'b1111011;
  localparam logic [6:0] PX  = 7'b1010101;
  localparam logic [6:0] PB  = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:6]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] frame_bcd;
  logic [3:0]  blank_mask;
  logic        frame_err;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;

  logic [0:6]  seg_b;
  logic [3:0]  sel_b;
  logic [15:0] bcd_b;
  logic [3:0]  blank_b;
  logic        err_b;
  logic        valid_b;
  logic        ready_b;
  logic        overrun_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_sel(dig_sel),
    .frame_bcd(frame_bcd), .blank_mask(blank_mask), .frame_err(frame_err),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
  );

  seg7_frame_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .seg(seg_b), .dig_sel(sel_b),
    .frame_bcd(bcd_b), .blank_mask(blank_b), .frame_err(err_b),
    .frame_valid(valid_b), .frame_ready(ready_b), .overrun(overrun_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    seg     = s;
    dig_sel = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_b(input logic [6:0] s, input logic [3:0] d, input int n);
    seg_b = s;
    sel_b = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd"},     32'(frame_bcd), 32'h0);
    chk({tag, "_blank"},   32'(blank_mask), 32'h0);
    chk({tag, "_err"},     32'(frame_err), 32'h0);
    chk({tag, "_valid"},   32'(frame_valid), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; seg = '0; dig_sel = '0; frame_ready = 1'b1;
    seg_b = '0; sel_b = '0; ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_valid_b", 32'(valid_b), 32'h0);
    rst_n = 1'b1;

    // Two digits accepted, then reset mid-frame
    hold(P8, 4'b0001, 4);
    hold(P8, 4'b0010, 4);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fresh frame: d2, d3 first; a stale mask would complete the frame here
    hold(P0, 4'b0100, 4);
    hold(P9, 4'b1000, 4);
    chk("stale_mask_valid", 32'(frame_valid), 32'h0);
    hold(P3, 4'b0001, 4);
    hold(P1, 4'b0010, 3);
    chk("pre16_valid", 32'(frame_valid), 32'h0);
    hold(P1, 4'b0010, 1);
    chk("f1_valid", 32'(frame_valid), 32'h1);
    chk("f1_bcd",   32'(frame_bcd), 32'h9013);
    chk("f1_blank", 32'(blank_mask), 32'h0);
    chk("f1_err",   32'(frame_err), 32'h0);

    // Short run on d1 then multi-hot select: nothing accepted
    hold(P8, 4'b0010, 3);
    chk("hs_valid_low", 32'(frame_valid), 32'h0);
    chk("hs_bcd_held",  32'(frame_bcd), 32'h9013);
    hold(P8, 4'b0011, 8);
    hold(P8, 4'b0001, 4);
    hold(PX, 4'b0100, 4);
    hold(PB, 4'b1000, 4);
    chk("no_d1_valid", 32'(frame_valid), 32'h0);
    hold(P8, 4'b0010, 4);
    chk("f2_valid", 32'(frame_valid), 32'h1);
    chk("f2_bcd",   32'(frame_bcd), 32'hFE88);
    chk("f2_blank", 32'(blank_mask), 32'h8);
    chk("f2_err",   32'(frame_err), 32'h1);

    // Consumer stalls while a second frame completes: dropped, overrun
    frame_ready = 1'b0;
    hold(P1, 4'b0001, 4);
    hold(P0, 4'b0010, 4);
    hold(P9, 4'b0100, 4);
    hold(P3, 4'b1000, 3);
    chk("pre_drop_overrun", 32'(overrun), 32'h0);
    hold(P3, 4'b1000, 1);
    chk("drop_overrun", 32'(overrun), 32'h1);
    chk("drop_valid",   32'(frame_valid), 32'h1);
    chk("drop_bcd",     32'(frame_bcd), 32'hFE88);
    chk("drop_blank",   32'(blank_mask), 32'h8);
    chk("drop_err",     32'(frame_err), 32'h1);
    frame_ready = 1'b1;
    hold(P3, 4'b1000, 1);
    chk("hs_overrun_clr", 32'(overrun), 32'h0);
    chk("hs_valid_clr",   32'(frame_valid), 32'h0);

    // Completion on the same edge as a handshake
    frame_ready = 1'b0;
    hold(P9, 4'b0001, 4);
    hold(P9, 4'b0010, 4);
    hold(P9, 4'b0100, 4);
    hold(P9, 4'b1000, 4);
    chk("f4_bcd", 32'(frame_bcd), 32'h9999);
    hold(P0, 4'b0001, 4);
    hold(P1, 4'b0010, 4);
    hold(P3, 4'b0100, 4);
    hold(P8, 4'b1000, 3);
    chk("f4_held", 32'(frame_bcd), 32'h9999);
    frame_ready = 1'b1;
    hold(P8, 4'b1000, 1);
    chk("same_edge_valid",   32'(frame_valid), 32'h1);
    chk("same_edge_bcd",     32'(frame_bcd), 32'h8310);
    chk("same_edge_overrun", 32'(overrun), 32'h0);
    hold(P8, 4'b1000, 1);
    chk("after_hs_valid", 32'(frame_valid), 32'h0);

    // STABLE_CYCLES=1: every changed sample is accepted
    hold_b(P1, 4'b0001, 1);
    hold_b(P3, 4'b0010, 1);
    hold_b(P9, 4'b0100, 1);
    chk("s1_pre_valid", 32'(valid_b), 32'h0);
    hold_b(P0, 4'b1000, 1);
    chk("s1_valid", 32'(valid_b), 32'h1);
    chk("s1_bcd",   32'(bcd_b), 32'h0931);
    hold_b(P8, 4'b0001, 1);
    hold_b(P8, 4'b0010, 1);
    hold_b(P8, 4'b0100, 1);
    hold_b(P8, 4'b1000, 1);
    chk("s1_overrun", 32'(overrun_b), 32'h1);
    chk("s1_held",    32'(bcd_b), 32'h0931);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
